svpwm_deadtime: RTL



---
 rtl/svpwm_pkg.sv | 20 ++
 rtl/svpwm_deadtime_if.sv | 28 ++
 rtl/svpwm_deadtime_channel.sv | 79 +++++++
 rtl/svpwm_deadtime.sv | 82 ++++++++
 4 files changed

// File: rtl/svpwm_pkg.sv
// Shared SVPWM types and constants for the modulator and dead-time stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svpwm_pkg;

  // Per-leg dead-time FSM state
  typedef enum logic [1:0] {
    OFF = 2'd0,
    DT  = 2'd1,
    HI  = 2'd2,
    LO  = 2'd3
  } dt_state_t;

  // Default dead time in core clocks
  localparam int DEAD_CYCLES_DFLT = 50;

  // PWM count period, shared with the modulator
  localparam int T = 4999;

endpackage

// File: rtl/svpwm_deadtime_if.sv
// Gate-driver bundle between the modulator/controller side and the dead-time stage.
// Latency: n/a (wiring only).
// Backpressure: none; levels are sampled every clock.
interface svpwm_deadtime_if;
  logic iEn;
  logic iPWM_u;
  logic iPWM_v;
  logic iPWM_w;
  logic iFault;
  logic iFault_clr;
  logic oPWM_uh;
  logic oPWM_ul;
  logic oPWM_vh;
  logic oPWM_vl;
  logic oPWM_wh;
  logic oPWM_wl;
  logic oFault;

  modport master (
    output iEn, iPWM_u, iPWM_v, iPWM_w, iFault, iFault_clr,
    input  oPWM_uh, oPWM_ul, oPWM_vh, oPWM_vl, oPWM_wh, oPWM_wl, oFault
  );

  modport slave (
    input  iEn, iPWM_u, iPWM_v, iPWM_w, iFault, iFault_clr,
    output oPWM_uh, oPWM_ul, oPWM_vh, oPWM_vl, oPWM_wh, oPWM_wl, oFault
  );
endinterface

// File: rtl/svpwm_deadtime_channel.sv
// One inverter leg: OFF/DT/HI/LO Moore FSM with dead-time counter.
// Latency: pwm edge to incoming gate DEAD_CYCLES+1 clocks; outgoing gate drops next clock.
// Backpressure: none; force_off overrides every state on the next clock.
module svpwm_deadtime_channel
  import svpwm_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DFLT,
  parameter int CNT_W       = 8
) (
  input  logic iClk,
  input  logic iRst,
  input  logic force_off,
  input  logic pwm,
  output logic gate_h,
  output logic gate_l
);

  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEAD_CYCLES - 1);

  dt_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and counter registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: every way into a conducting state passes through a full DT
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (force_off) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = DT;
          cnt_nxt   = '0;
        end
        HI: begin
          if (!pwm) begin
            state_nxt = DT;
            cnt_nxt   = '0;
          end
        end
        LO: begin
          if (pwm) begin
            state_nxt = DT;
            cnt_nxt   = '0;
          end
        end
        DT: begin
          if (cnt == DT_LAST) begin
            state_nxt = pwm ? HI : LO;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Gates decode the registered state, so they are glitch-free and exclusive
  assign gate_h = (state == HI);
  assign gate_l = (state == LO);

endmodule

// File: rtl/svpwm_deadtime.sv
// Three-leg dead-time inserter with enable and fault shutdown (SVPWM_DT_FAULT_LATCH_EN: sticky fault).
// Latency: pwm edge to incoming gate DEAD_CYCLES+1 clocks; fault/!iEn to gates off 1 clock.
// Backpressure: none; free-running, inputs sampled every clock.
module svpwm_deadtime
  import svpwm_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DFLT,
  parameter int CNT_W       = 8
) (
  input  logic iClk,
  input  logic iRst,
  svpwm_deadtime_if.slave bus
);

  if (DEAD_CYCLES < 1) begin : g_bad_dead
    $error("svpwm_deadtime: DEAD_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(DEAD_CYCLES)) begin : g_bad_cnt_w
    $error("svpwm_deadtime: CNT_W too narrow for DEAD_CYCLES");
  end

  logic fault_act;
  logic force_off;
  logic fault_q;
  logic uh, ul, vh, vl, wh, wl;

`ifdef SVPWM_DT_FAULT_LATCH_EN
  logic fault_latch;

  // Sticky fault latch; a simultaneous set and clear keeps it set
  always_ff @(posedge iClk) begin
    if (iRst) begin
      fault_latch <= 1'b0;
    end else if (bus.iFault) begin
      fault_latch <= 1'b1;
    end else if (bus.iFault_clr) begin
      fault_latch <= 1'b0;
    end
  end

  assign fault_act = fault_latch | bus.iFault;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = bus.iFault_clr;
  assign fault_act        = bus.iFault;
`endif

  assign force_off = fault_act | ~bus.iEn;

  // Registered fault flag
  always_ff @(posedge iClk) begin
    if (iRst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_act;
    end
  end

  svpwm_deadtime_channel #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_ch_u (
    .iClk(iClk), .iRst(iRst), .force_off(force_off),
    .pwm(bus.iPWM_u), .gate_h(uh), .gate_l(ul)
  );

  svpwm_deadtime_channel #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_ch_v (
    .iClk(iClk), .iRst(iRst), .force_off(force_off),
    .pwm(bus.iPWM_v), .gate_h(vh), .gate_l(vl)
  );

  svpwm_deadtime_channel #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_ch_w (
    .iClk(iClk), .iRst(iRst), .force_off(force_off),
    .pwm(bus.iPWM_w), .gate_h(wh), .gate_l(wl)
  );

  assign bus.oPWM_uh = uh;
  assign bus.oPWM_ul = ul;
  assign bus.oPWM_vh = vh;
  assign bus.oPWM_vl = vl;
  assign bus.oPWM_wh = wh;
  assign bus.oPWM_wl = wl;
  assign bus.oFault  = fault_q;

endmodule
